// File: rtl/neuron_mac_lanes.sv
// neuron_mac_lanes: multi-lane fixed-point multiply-accumulate neuron.
// Consumes LANES input/weight pairs per beat, adds a bias, applies linear or
// ReLU activation and saturates the rescaled result to OUT_W bits.
// Optional macro NEURON_MAC_ROUND_EN: round half-up on the discarded fraction
// instead of truncating toward minus infinity.
module neuron_mac_lanes #(
  parameter int DATA_W     = 16,
  parameter int FRAC_BITS  = 15,
  parameter int OUT_W      = 16,
  parameter int LANES      = 4,
  parameter int NUM_INPUTS = 784,
  parameter int ACC_W      = 48
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] data_in,
  input  logic [LANES*DATA_W-1:0] weight_in,
  input  logic [DATA_W-1:0]       bias_in,
  input  logic                    act_relu,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        data_out,
  output logic                    out_sat
);

  localparam int BEATS      = (NUM_INPUTS + LANES - 1) / LANES;
  localparam int LAST_LANES = NUM_INPUTS - (BEATS - 1) * LANES;
  localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [1:0] ST_ACC   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_OUT   = 2'd2;

  localparam logic signed [ACC_W-1:0] OUT_MAX =
    {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN =
    {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [1:0]               state_q, state_d;
  logic [CNT_W-1:0]         beat_cnt_q, beat_cnt_d;
  logic                     p_valid_q, p_valid_d;
  logic                     p_last_q, p_last_d;
  logic signed [ACC_W-1:0]  p_sum_q, p_sum_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     a_last_q, a_last_d;
  logic signed [DATA_W-1:0] bias_q, bias_d;
  logic                     relu_q, relu_d;
  logic                     out_valid_q, out_valid_d;
  logic [OUT_W-1:0]         data_out_q, data_out_d;
  logic                     out_sat_q, out_sat_d;

  logic                      in_fire;
  logic                      last_beat;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]   s_fin;
  logic signed [ACC_W-1:0]   r_fin;
  logic [OUT_W-1:0]          fin_data;
  logic                      fin_sat;

  assign in_ready  = (state_q == ST_ACC);
  assign in_fire   = in_valid && in_ready;
  assign last_beat = (beat_cnt_q == CNT_W'(BEATS - 1));
  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
  assign out_sat   = out_sat_q;

  // Lane products summed into one beat total; padding lanes of the final beat are dropped.
  always_comb begin
    p_sum_d = '0;
    prod    = '0;
    for (int l = 0; l < LANES; l++) begin
      prod = $signed(data_in[l*DATA_W +: DATA_W]) * $signed(weight_in[l*DATA_W +: DATA_W]);
      if (!(last_beat && (l >= LAST_LANES))) begin
        p_sum_d = p_sum_d + ACC_W'(prod);
      end
    end
  end

  // Bias add, rescale, activation and clip of the completed accumulator.
  always_comb begin
    s_fin = acc_q + (ACC_W'(bias_q) << FRAC_BITS);
`ifdef NEURON_MAC_ROUND_EN
    s_fin = s_fin + (ACC_W'(1) << (FRAC_BITS - 1));
`endif
    r_fin = s_fin >>> FRAC_BITS;
    if (relu_q && r_fin[ACC_W-1]) begin
      r_fin = '0;
    end
    fin_data = r_fin[OUT_W-1:0];
    fin_sat  = 1'b0;
    if (r_fin > OUT_MAX) begin
      fin_data = OUT_MAX[OUT_W-1:0];
      fin_sat  = 1'b1;
    end else if (r_fin < OUT_MIN) begin
      fin_data = OUT_MIN[OUT_W-1:0];
      fin_sat  = 1'b1;
    end
  end

  // Control: beat counting, accumulation, drain wait and output hold.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    p_valid_d   = in_fire;
    p_last_d    = in_fire && last_beat;
    acc_d       = acc_q;
    a_last_d    = a_last_q;
    bias_d      = bias_q;
    relu_d      = relu_q;
    out_valid_d = out_valid_q;
    data_out_d  = data_out_q;
    out_sat_d   = out_sat_q;

    if (p_valid_q) begin
      acc_d = acc_q + p_sum_q;
      if (p_last_q) begin
        a_last_d = 1'b1;
      end
    end

    case (state_q)
      ST_ACC: begin
        if (in_fire) begin
          if (last_beat) begin
            beat_cnt_d = '0;
            bias_d     = $signed(bias_in);
            relu_d     = act_relu;
            state_d    = ST_DRAIN;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (a_last_q) begin
          a_last_d    = 1'b0;
          data_out_d  = fin_data;
          out_sat_d   = fin_sat;
          out_valid_d = 1'b1;
          state_d     = ST_OUT;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          state_d     = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  // State registers; reset abandons any partial neuron immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACC;
      beat_cnt_q  <= '0;
      p_valid_q   <= 1'b0;
      p_last_q    <= 1'b0;
      p_sum_q     <= '0;
      acc_q       <= '0;
      a_last_q    <= 1'b0;
      bias_q      <= '0;
      relu_q      <= 1'b0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      p_valid_q   <= p_valid_d;
      p_last_q    <= p_last_d;
      p_sum_q     <= p_sum_d;
      acc_q       <= acc_d;
      a_last_q    <= a_last_d;
      bias_q      <= bias_d;
      relu_q      <= relu_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
      out_sat_q   <= out_sat_d;
    end
  end

endmodule
